// File: rtl/pc_unit_pkg.sv
// Shared CPU definitions: PC type, reset vector, decoder opcodes.
// Used by pc_unit and ret_stack; error logic is enabled by PC_UNIT_ERR_EN.
package pc_unit_pkg;

    localparam int CPU_PC_WIDTH    = 5;
    localparam int CPU_STACK_DEPTH = 8;

    typedef logic [CPU_PC_WIDTH-1:0] pc_t;

    localparam pc_t PC_RESET = '0;

    localparam logic [3:0] JMP     = 4'h1;
    localparam logic [3:0] IF0JUMP = 4'h2;
    localparam logic [3:0] IF1JUMP = 4'h3;
    localparam logic [3:0] CALL    = 4'h4;
    localparam logic [3:0] CAL0    = 4'h5;
    localparam logic [3:0] CAL1    = 4'h6;
    localparam logic [3:0] RET     = 4'h7;
    localparam logic [3:0] RET0    = 4'h8;
    localparam logic [3:0] RET1    = 4'h9;

    typedef enum logic [1:0] {
        SEL_SEQ,
        SEL_JMP,
        SEL_RET
    } pc_sel_e;

endpackage

// File: rtl/pc_unit_ret_stack.sv
// Return-address LIFO: counter-based pointer, top-of-stack read port.
// Entry storage is not reset; only entries below depth are ever read.
import pc_unit_pkg::*;

module ret_stack #(
    parameter int WIDTH = CPU_PC_WIDTH,
    parameter int DEPTH = CPU_STACK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] depth,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DW-1:0]    cnt;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt == DW'(DEPTH));
    assign empty   = (cnt == '0);
    assign depth   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && !full && !do_pop;
    assign wr_idx  = AW'(cnt);
    assign rd_idx  = AW'(cnt - DW'(1));
    assign rdata   = empty ? '0 : mem[rd_idx];

    // Entry count; a pop takes precedence over a simultaneous push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (do_pop) begin
            cnt <= cnt - DW'(1);
        end else if (do_push) begin
            cnt <= cnt + DW'(1);
        end
    end

    // Entry storage written at the current count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_idx] <= wdata;
        end
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter with call/return stack, priority ret > cal > jmp > seq.
// Define PC_UNIT_ERR_EN to build the sticky ovf_err/unf_err flags.
import pc_unit_pkg::*;

module pc_unit #(
    parameter int PC_WIDTH    = CPU_PC_WIDTH,
    parameter int STACK_DEPTH = CPU_STACK_DEPTH
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             en,
    input  logic                             jmp,
    input  logic                             cal,
    input  logic                             ret,
    input  logic [PC_WIDTH-1:0]              jmp_addr,
    input  logic                             err_clr,
    output logic [PC_WIDTH-1:0]              pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0] depth,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             ovf_err,
    output logic                             unf_err
);

    pc_sel_e             sel;
    logic                push;
    logic                pop;
    logic                ovf_set;
    logic                unf_set;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] top;
    logic [PC_WIDTH-1:0] pc_next;

    assign pc_inc = pc + PC_WIDTH'(1);

    ret_stack #(
        .WIDTH (PC_WIDTH),
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (top),
        .depth (depth),
        .full  (stack_full),
        .empty (stack_empty)
    );

    // Decode strobes; a blocked call/return falls through to pc+1.
    always_comb begin
        sel     = SEL_SEQ;
        push    = 1'b0;
        pop     = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        if (en) begin
            priority case (1'b1)
                ret: begin
                    if (!stack_empty) begin
                        sel = SEL_RET;
                        pop = 1'b1;
                    end else begin
                        unf_set = 1'b1;
                    end
                end
                cal: begin
                    if (!stack_full) begin
                        sel  = SEL_JMP;
                        push = 1'b1;
                    end else begin
                        ovf_set = 1'b1;
                    end
                end
                jmp:     sel = SEL_JMP;
                default: sel = SEL_SEQ;
            endcase
        end
    end

    // Next-PC mux.
    always_comb begin
        unique case (sel)
            SEL_RET: pc_next = top;
            SEL_JMP: pc_next = jmp_addr;
            default: pc_next = pc_inc;
        endcase
    end

    // Program counter register, held while en is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= PC_WIDTH'(PC_RESET);
        end else if (en) begin
            pc <= pc_next;
        end
    end

`ifdef PC_UNIT_ERR_EN
    // Sticky error flags; a new error beats a same-cycle clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_err <= 1'b0;
            unf_err <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err <= 1'b1;
            end else if (err_clr) begin
                ovf_err <= 1'b0;
            end
            if (unf_set) begin
                unf_err <= 1'b1;
            end else if (err_clr) begin
                unf_err <= 1'b0;
            end
        end
    end
`else
    logic unused_err;

    assign ovf_err    = 1'b0;
    assign unf_err    = 1'b0;
    assign unused_err = ^{err_clr, ovf_set, unf_set};
`endif

endmodule

// File: doc/pc_unit.md
# pc_unit

Program-counter and return-address-stack stage sitting directly downstream of the instruction decoder. It consumes the decoder's `jmp`, `cal`, `ret` strobes and `jmp_addr`, and produces the registered program counter that addresses instruction memory. It also keeps a private LIFO of return addresses for call/return. One instruction is retired per enabled clock.

## Interface
- `PC_WIDTH`, 5: width of program counter and jump address.
- `STACK_DEPTH`, 8: number of return-address entries; ≥2, power of two not required.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `en` input 1: advance enable; 0 = hold all state (halt/stall).
- `jmp` input 1: unconditional/conditional jump already resolved by decoder.
- `cal` input 1: call; push return address, jump.
- `ret` input 1: return; pop return address into PC.
- `jmp_addr` input PC_WIDTH: jump/call target.
- `err_clr` input 1: clears sticky error flags.
- `pc` output PC_WIDTH: current program counter (registered).
- `depth` output $clog2(STACK_DEPTH+1): number of valid stack entries.
- `stack_full` output 1: `depth == STACK_DEPTH`.
- `stack_empty` output 1: `depth == 0`.
- `ovf_err` output 1: sticky, call attempted while full.
- `unf_err` output 1: sticky, return attempted while empty.

## Operation
- Next-PC selection when `en`=1, priority ret > cal > jmp > sequential:
  - `ret`, stack non-empty: `pc <= top`, `depth--`.
  - `ret`, stack empty: `pc <= pc+1`, `unf_err <= 1`, depth unchanged.
  - `cal` (decoder asserts `jmp` together with it; `cal` wins), not full: push `pc+1` (mod 2^PC_WIDTH), `pc <= jmp_addr`, `depth++`.
  - `cal`, full: no push, no jump, `pc <= pc+1`, `ovf_err <= 1`.
  - `jmp` only: `pc <= jmp_addr`.
  - none: `pc <= pc+1`.
- PC arithmetic is modulo 2^PC_WIDTH; `pc` of all-ones increments to 0; pushed return address wraps identically.
- `en`=0: pc, depth, stack contents and error flags hold; strobes ignored. `err_clr` still acts.
- `err_clr`=1: both flags cleared next edge; if a new error occurs in the same cycle, the set wins.
- Stack entries are never read beyond `depth`; contents after reset are don't-care.

## Timing
- Reset (async assert, sync-safe release): `pc`=0, `depth`=0, `stack_empty`=1, `stack_full`=0, `ovf_err`=0, `unf_err`=0.
- Reset asserted mid-call/return: any in-flight push/pop is discarded; state is exactly the reset state.
- Strobes and `jmp_addr` are sampled at the rising edge; `pc` changes one cycle after sampling (one-cycle latency). Instruction memory and decoder are combinational from `pc`, so the strobes for instruction at `pc` are valid in the same cycle.
- `depth`, `stack_full`, `stack_empty` update in the same edge as `pc`; flags are combinational from `depth`.
- Error flags assert the edge after the offending cycle and stay high until `err_clr` or reset.

## Configuration
- `PC_UNIT_ERR_EN` defined: `ovf_err`/`unf_err` registers and `err_clr` logic are implemented as above.
- Not defined: `ovf_err` and `unf_err` tied to 0, `err_clr` ignored; overflow/underflow protection (no push when full, no pop when empty, fall through to `pc+1`) remains identical.

## Structure
- Shared CPU package holds: `pc_t` typedef (logic [PC_WIDTH-1:0]), the opcode constants used by the decoder (JMP, IF0JUMP, IF1JUMP, CALL, CAL0, CAL1, RET, RET0, RET1), and a `PC_RESET` constant (0).
- One sub-module: `ret_stack`, a parameterised LIFO (push, pop, wdata, rdata=top, depth, full, empty) with async active-low reset on its pointer; `pc_unit` owns next-PC mux and error flags.

## Test plan
- Reset then 40 cycles no strobes, `en`=1 -> pc 0,1,…,31,0,1,… (wrap at 31→0), depth 0 throughout.
- At pc=3 assert `cal`+`jmp`, `jmp_addr`=20; at pc=22 assert `ret` -> pc 3→20, depth 1, then 22→4, depth 0.
- Nested 8 calls from pc=1, targets 10..17 -> depth 8, stack_full=1; ninth call at pc=18 -> pc=19, depth 8, ovf_err=1 next cycle; 8 returns -> pcs pop in reverse order ending at pc=2.
- `ret` with empty stack at pc=7 -> pc=8, unf_err=1; `err_clr` pulse -> unf_err=0; `err_clr` same cycle as another empty `ret` -> unf_err stays 1.
- `en`=0 for 5 cycles while `jmp`=1, `jmp_addr`=9 at pc=4 -> pc holds 4; `en`=1 -> pc=9.
- Assert `rst_n`=0 between clock edges right after a call (depth 1, pc=20) -> pc=0, depth 0 immediately, no clock required; first `ret` afterwards -> unf_err=1 (with `PC_UNIT_ERR_EN`), 0 without.
